// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
// Holds the default 640x480@60 timing constants, the derived line/frame
// totals and sync window bounds, and the coordinate type used by the
// raster generator and its consumers. Sync windows are half-open:
// [HS_START, HS_END) and [VS_START, VS_END).
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

endpackage

// File: rtl/vga_timing_gen_pix_tick_div.sv
// Pixel-rate divider.
// Counts system clocks 0..CLK_DIV-1 and wraps. tick is high during the last
// system clock of each pixel period, so the parent can load its pixel-rate
// registers on the same edge that its registered pixel enable rises.
// With CLK_DIV=1 tick is constantly high.
// Ports:
//   Clk     - system clock
//   Reset_n - asynchronous active-low reset (divider restarts at 0)
//   tick    - high in the final Clk of each CLK_DIV-long pixel period
module pix_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60).
// Divides Clk into a pixel enable, runs horizontal/vertical position
// counters at pixel rate and drives registered coordinates, syncs,
// blanking and frame-event strobes, all loaded on the same edge so there is
// no skew between them.
// Ports:
//   Clk          - system clock
//   Reset_n      - asynchronous active-low reset
//   pix_en       - one-Clk pixel tick; DrawX/DrawY valid to sample when high
//   DrawX/DrawY  - current column/line (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   hs/vs        - horizontal/vertical sync, active low
//   blank_n      - high inside the visible window
//   frame_start  - one-Clk pulse when (0,0) is loaded
//   vblank_start - one-Clk pulse when (0,V_VISIBLE) is loaded
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP      = vga_timing_pkg::H_FP,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP
) (
  input  logic   Clk,
  input  logic   Reset_n,
  output logic   pix_en,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   hs,
  output logic   vs,
  output logic   blank_n,
  output logic   frame_start,
  output logic   vblank_start
);

  localparam int hTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int vTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t hLast   = coord_t'(hTotal - 1);
  localparam coord_t vLast   = coord_t'(vTotal - 1);
  localparam coord_t hVis    = coord_t'(H_VISIBLE);
  localparam coord_t vVis    = coord_t'(V_VISIBLE);
  localparam coord_t hsStart = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t hsEnd   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t vsStart = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t vsEnd   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  logic   pixTick;
  coord_t hc;
  coord_t vc;
  coord_t hcNext;
  coord_t vcNext;

  pix_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .tick    (pixTick)
  );

  // Next raster position. Counters reset to the last position so the first
  // tick after reset wraps cleanly to (0,0).
  always_comb begin
    hcNext = (hc == hLast) ? '0 : hc + 10'd1;
    vcNext = vc;
    if (hc == hLast) begin
      vcNext = (vc == vLast) ? '0 : vc + 10'd1;
    end
  end

  // All outputs decode from the new position and load on the same edge as
  // the counters; strobes are cleared on every other cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc           <= hLast;
      vc           <= vLast;
      pix_en       <= 1'b0;
      DrawX        <= '0;
      DrawY        <= '0;
      hs           <= 1'b1;
      vs           <= 1'b1;
      blank_n      <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      pix_en       <= pixTick;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      if (pixTick) begin
        hc           <= hcNext;
        vc           <= vcNext;
        DrawX        <= hcNext;
        DrawY        <= vcNext;
        hs           <= !((hcNext >= hsStart) && (hcNext < hsEnd));
        vs           <= !((vcNext >= vsStart) && (vcNext < vsEnd));
        blank_n      <= (hcNext < hVis) && (vcNext < vVis);
        frame_start  <= (hcNext == '0) && (vcNext == '0);
        vblank_start <= (hcNext == '0) && (vcNext == vVis);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing CLK_DIV=2 instance (A), and two
// reduced-timing instances with CLK_DIV=1 (B) and CLK_DIV=3 (C). C receives
// an asynchronous reset mid-frame.
module tb_vga_timing_gen;

  localparam int NCYC = 3300;

  logic Clk;
  logic rst;
  logic rstC;

  logic       pixEnA, hsA, vsA, blankA, fsA, vbsA;
  logic [9:0] drawXA, drawYA;
  logic       pixEnB, hsB, vsB, blankB, fsB, vbsB;
  logic [9:0] drawXB, drawYB;
  logic       pixEnC, hsC, vsC, blankC, fsC, vbsC;
  logic [9:0] drawXC, drawYC;

  int nTests;
  int nFail;
  logic [31:0] exp_q[$];

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- DUTs ----------------
  vga_timing_gen dutA (
    .Clk(Clk), .Reset_n(rst), .pix_en(pixEnA), .DrawX(drawXA), .DrawY(drawYA),
    .hs(hsA), .vs(vsA), .blank_n(blankA), .frame_start(fsA), .vblank_start(vbsA)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dutB (
    .Clk(Clk), .Reset_n(rst), .pix_en(pixEnB), .DrawX(drawXB), .DrawY(drawYB),
    .hs(hsB), .vs(vsB), .blank_n(blankB), .frame_start(fsB), .vblank_start(vbsB)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dutC (
    .Clk(Clk), .Reset_n(rstC), .pix_en(pixEnC), .DrawX(drawXC), .DrawY(drawYC),
    .hs(hsC), .vs(vsC), .blank_n(blankC), .frame_start(fsC), .vblank_start(vbsC)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs kk Clk edges after reset release (kk=0: in reset).
  // Pixel p is loaded at edge D*(p+1); position follows from p by div/mod.
  task automatic model(input int kk, input int d, input int ht, input int vt,
                       input int hv, input int vv, input int hss, input int hse,
                       input int vss, input int vse, output logic [25:0] e);
    logic pe;
    int t, p, hc, vc;
    logic hsE, vsE, bl, fs, vb;
    pe = (kk >= d) && (kk % d == 0);
    t  = kk / d;
    if (t == 0) begin
      e = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    end else begin
      p   = t - 1;
      hc  = p % ht;
      vc  = (p / ht) % vt;
      hsE = !((hc >= hss) && (hc < hse));
      vsE = !((vc >= vss) && (vc < vse));
      bl  = (hc < hv) && (vc < vv);
      fs  = pe && (hc == 0) && (vc == 0);
      vb  = pe && (hc == 0) && (vc == vv);
      e   = {pe, 10'(hc), 10'(vc), hsE, vsE, bl, fs, vb};
    end
  endtask

  task automatic check_inst(input string nm, input logic [25:0] act, input logic [25:0] e);
    check({nm, "_pix_en"},       32'(act[25]),    32'(e[25]));
    check({nm, "_DrawX"},        32'(act[24:15]), 32'(e[24:15]));
    check({nm, "_DrawY"},        32'(act[14:5]),  32'(e[14:5]));
    check({nm, "_hs"},           32'(act[4]),     32'(e[4]));
    check({nm, "_vs"},           32'(act[3]),     32'(e[3]));
    check({nm, "_blank_n"},      32'(act[2]),     32'(e[2]));
    check({nm, "_frame_start"},  32'(act[1]),     32'(e[1]));
    check({nm, "_vblank_start"}, 32'(act[0]),     32'(e[0]));
  endtask

  task automatic model_a(input int kk, output logic [25:0] e);
    model(kk, 2, 800, 525, 640, 480, 656, 752, 490, 492, e);
  endtask

  task automatic model_small(input int kk, input int d, output logic [25:0] e);
    model(kk, d, 24, 16, 16, 10, 18, 21, 12, 14, e);
  endtask

  function automatic logic [25:0] act_a();
    return {pixEnA, drawXA, drawYA, hsA, vsA, blankA, fsA, vbsA};
  endfunction
  function automatic logic [25:0] act_b();
    return {pixEnB, drawXB, drawYB, hsB, vsB, blankB, fsB, vbsB};
  endfunction
  function automatic logic [25:0] act_c();
    return {pixEnC, drawXC, drawYC, hsC, vsC, blankC, fsC, vbsC};
  endfunction

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [25:0] e;
    logic prevHsA, prevBlankA;
    logic [9:0] prevYA;
    int kc;
    int fsCntA, vbsCntA, fsCntB, vbsCntB, vsLowB, fsCntC, vbsCntC;
    int kSecondFsB, kFirstFsC;

    nTests = 0; nFail = 0;
    fsCntA = 0; vbsCntA = 0; fsCntB = 0; vbsCntB = 0; vsLowB = 0;
    fsCntC = 0; vbsCntC = 0; kSecondFsB = -1; kFirstFsC = -1;
    rst = 1'b0; rstC = 1'b0;

    repeat (3) @(negedge Clk);
    model_a(0, e);        check_inst("rstA", act_a(), e);
    model_small(0, 1, e); check_inst("rstB", act_b(), e);
    model_small(0, 3, e); check_inst("rstC", act_c(), e);

    // Hand-computed Clk edges of line events on A (pixel p loads at 2*(p+1)):
    // blank fall, hs fall, hs rise, DrawY change, for lines 0 and 1.
    exp_q.push_back(32'd1282); exp_q.push_back(32'd1314);
    exp_q.push_back(32'd1506); exp_q.push_back(32'd1602);
    exp_q.push_back(32'd2882); exp_q.push_back(32'd2914);
    exp_q.push_back(32'd3106); exp_q.push_back(32'd3202);

    prevHsA = 1'b1; prevBlankA = 1'b0; prevYA = '0;
    rst = 1'b1; rstC = 1'b1;

    for (int k = 1; k <= NCYC; k++) begin
      @(negedge Clk);
      model_a(k, e);        check_inst("A", act_a(), e);
      model_small(k, 1, e); check_inst("B", act_b(), e);
      kc = (k <= 310) ? k : ((k <= 312) ? 0 : k - 312);
      model_small(kc, 3, e); check_inst("C", act_c(), e);

      if ((prevBlankA && !blankA) || (prevHsA !== hsA) || (prevYA !== drawYA)) begin
        if (exp_q.size() == 0) check("a_event_extra", 32'(k), 32'd0);
        else check("a_event", 32'(k), exp_q.pop_front());
      end
      prevHsA = hsA; prevBlankA = blankA; prevYA = drawYA;

      if (fsA) fsCntA++;
      if (vbsA) vbsCntA++;
      if (fsB) begin
        fsCntB++;
        if (fsCntB == 2) kSecondFsB = k;
      end
      if (vbsB) vbsCntB++;
      if (!vsB) vsLowB++;
      if (fsC) begin
        fsCntC++;
        if (k > 312 && kFirstFsC < 0) kFirstFsC = k;
      end
      if (vbsC) vbsCntC++;

      if (k == 310) begin
        #2 rstC = 1'b0;
        #1;
        model_small(0, 3, e); check_inst("C_async", act_c(), e);
      end
      if (k == 312) rstC = 1'b1;
    end

    check("a_events_left", 32'(exp_q.size()), 32'd0);
    check("a_fs_count", 32'(fsCntA), 32'd1);
    check("a_vbs_count", 32'(vbsCntA), 32'd0);
    check("b_fs_count", 32'(fsCntB), 32'd9);
    check("b_vbs_count", 32'(vbsCntB), 32'd8);
    check("b_vs_low_cycles", 32'(vsLowB), 32'd384);
    check("b_frame_len", 32'(kSecondFsB), 32'd385);
    check("c_fs_count", 32'(fsCntC), 32'd4);
    check("c_vbs_count", 32'(vbsCntC), 32'd2);
    check("c_restart_fs", 32'(kFirstFsC), 32'd315);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
